// File: rtl/lbist_pkg.sv
// Shared types, encodings and LFSR step function for the LBIST pattern generator.
package lbist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2,
    DONE    = 2'd3
  } lbist_state_e;

  localparam logic [31:0] RV_NOP     = 32'h0000_0013;
  localparam logic [6:0]  OPC_OPIMM  = 7'h13;
  localparam logic [6:0]  OPC_OP     = 7'h33;
  localparam logic [6:0]  OPC_STORE  = 7'h23;
  localparam int          LFSR_MAX_W = 32;

  // Fibonacci step on a register of 'width' live bits; bits above 'width' stay zero.
  function automatic logic [LFSR_MAX_W-1:0] lbist_lfsr_next(
    input logic [LFSR_MAX_W-1:0] lfsr,
    input logic [LFSR_MAX_W-1:0] poly,
    input int unsigned           width
  );
    logic                  fb;
    logic [LFSR_MAX_W-1:0] mask;
    fb   = ^(lfsr & poly);
    mask = (width >= LFSR_MAX_W) ? '1
                                 : ((LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1));
    return ((lfsr << 1) | LFSR_MAX_W'(fb)) & mask;
  endfunction

endpackage

// File: rtl/lbist_pattern_gen_if.sv
// Control/observe bundle between the BIST controller / fetch path and the pattern generator.
interface lbist_pattern_gen_if #(
  parameter int LFSR_W = 16,
  parameter int IMM_W  = 12,
  parameter int N_RAND = 4,
  parameter int ROUNDS = 8
);
  logic                          TPG;
  logic [31:0]                   PC;
  logic                          round_next;
  logic                          seed_load;
  logic [LFSR_W-1:0]             seed_in;
  logic [31:0]                   test_pattern;
  logic [N_RAND*IMM_W-1:0]       rand_values;
  logic                          rand_valid;
  logic [$clog2(ROUNDS+1)-1:0]   round_cnt;
  logic                          done;

  modport master (
    output TPG, PC, round_next, seed_load, seed_in,
    input  test_pattern, rand_values, rand_valid, round_cnt, done
  );

  modport slave (
    input  TPG, PC, round_next, seed_load, seed_in,
    output test_pattern, rand_values, rand_valid, round_cnt, done
  );
endinterface

// File: rtl/lbist_inst_rom.sv
// Fixed test program: ALU ops over the random-seeded registers, then stores of x1..x8.
module lbist_inst_rom
  import lbist_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int N_RAND = 4
) (
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  output logic [31:0]              inst_o
);

  localparam int N_ALU = 5;
  localparam int N_ST  = 8;

  int          j;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [11:0] off;

  always_comb begin
    inst_o = RV_NOP;
    j      = int'(idx_i) - N_RAND;
    rs1    = '0;
    rs2    = '0;
    rd     = '0;
    off    = '0;
    if (j >= 0 && j < N_ALU) begin
      rs1 = 5'((j % N_RAND) + 1);
      rs2 = 5'(((j + 1) % N_RAND) + 1);
      rd  = 5'(((N_RAND + j) % 31) + 1);
      case (j)
        0:       inst_o = {7'h00, rs2, rs1, 3'b000, rd, OPC_OP};
        1:       inst_o = {7'h20, rs2, rs1, 3'b000, rd, OPC_OP};
        2:       inst_o = {7'h00, rs2, rs1, 3'b100, rd, OPC_OP};
        3:       inst_o = {7'h00, rs2, rs1, 3'b110, rd, OPC_OP};
        default: inst_o = {7'h00, rs2, rs1, 3'b111, rd, OPC_OP};
      endcase
    end else if (j >= N_ALU && j < N_ALU + N_ST) begin
      rs2    = 5'(j - N_ALU + 1);
      off    = 12'(4 * (j - N_ALU));
      inst_o = {off[11:5], rs2, 5'd0, 3'b010, off[4:0], OPC_STORE};
    end
  end

endmodule

// File: rtl/lbist_pattern_gen.sv
// LBIST pattern generator: LFSR-seeded addi slots followed by a fixed ROM program, over several rounds.
// state   | meaning
// IDLE    | TPG low, nothing captured
// CAPTURE | sampling one LFSR immediate per cycle into rand_values
// READY   | immediates valid, addi slots served, waiting for round_next
// DONE    | all rounds complete, held until TPG drops
module lbist_pattern_gen
  import lbist_pkg::*;
#(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY = 16'hD008,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                IMM_W     = 12,
  parameter int                N_RAND    = 4,
  parameter int                DEPTH     = 32,
  parameter int                ROUNDS    = 8
) (
  input logic               clk,
  input logic               nRst,
  lbist_pattern_gen_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ROUNDS + 1);

  lbist_state_e            state_q, state_d;
  logic [4:0]              cap_idx_q, cap_idx_d;
  logic [N_RAND*IMM_W-1:0] rand_q, rand_d;
  logic [CW-1:0]           round_q, round_d;
  logic [LFSR_MAX_W-1:0]   lfsr_q, lfsr_d;

  logic [AW-1:0]           widx;
  logic                    in_range;
  logic [IMM_W-1:0]        imm_sel;
  logic [31:0]             rom_inst;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= IDLE;
      cap_idx_q <= '0;
      rand_q    <= '0;
      round_q   <= '0;
      lfsr_q    <= LFSR_MAX_W'(SEED);
    end else begin
      state_q   <= state_d;
      cap_idx_q <= cap_idx_d;
      rand_q    <= rand_d;
      round_q   <= round_d;
      lfsr_q    <= lfsr_d;
    end
  end

  // A zero seed would lock the LFSR, so it falls back to the reset seed.
  always_comb begin
    if (bus.seed_load) begin
      lfsr_d = (bus.seed_in == '0) ? LFSR_MAX_W'(SEED) : LFSR_MAX_W'(bus.seed_in);
    end else begin
      lfsr_d = lbist_lfsr_next(lfsr_q, LFSR_MAX_W'(LFSR_POLY), LFSR_W);
    end
  end

  always_comb begin
    state_d   = state_q;
    cap_idx_d = cap_idx_q;
    rand_d    = rand_q;
    round_d   = round_q;
    if (!bus.TPG) begin
      state_d   = IDLE;
      cap_idx_d = '0;
      rand_d    = '0;
      round_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = CAPTURE;
          cap_idx_d = '0;
        end
        CAPTURE: begin
          rand_d[cap_idx_q*IMM_W +: IMM_W] = lfsr_q[IMM_W-1:0];
          if (cap_idx_q == 5'(N_RAND - 1)) begin
            state_d   = READY;
            cap_idx_d = '0;
          end else begin
            cap_idx_d = cap_idx_q + 5'd1;
          end
        end
        READY: begin
          if (bus.round_next) begin
            if (round_q < CW'(ROUNDS)) round_d = round_q + CW'(1);
            if (round_d == CW'(ROUNDS)) begin
              state_d = DONE;
            end else begin
              state_d   = CAPTURE;
              cap_idx_d = '0;
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign widx     = bus.PC[AW+1:2];
  assign in_range = (bus.PC < 32'(4 * DEPTH)) && (bus.PC[1:0] == 2'b00);

  lbist_inst_rom #(
    .DEPTH  (DEPTH),
    .N_RAND (N_RAND)
  ) u_rom (
    .idx_i  (widx),
    .inst_o (rom_inst)
  );

  always_comb begin
    bus.test_pattern = '0;
    imm_sel          = '0;
    if (bus.TPG) begin
      if (!in_range) begin
        bus.test_pattern = RV_NOP;
      end else if (widx < AW'(N_RAND)) begin
        if (state_q == READY) begin
          imm_sel          = rand_q[widx*IMM_W +: IMM_W];
          bus.test_pattern = {12'(imm_sel), 5'd0, 3'b000, 5'(32'(widx) + 1), OPC_OPIMM};
        end else begin
          bus.test_pattern = RV_NOP;
        end
      end else begin
        bus.test_pattern = rom_inst;
      end
    end
  end

  assign bus.rand_values = rand_q;
  assign bus.rand_valid  = (state_q == READY);
  assign bus.done        = (state_q == DONE);
  assign bus.round_cnt   = round_q;

endmodule

// File: tb/tb_lbist_pattern_gen.sv
// Directed bench for lbist_pattern_gen with an independent LFSR model and an immediate scoreboard.
module tb_lbist_pattern_gen;

  localparam int          N_RAND = 4;
  localparam int          IMM_W  = 12;
  localparam int          ROUNDS = 8;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk  = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  lbist_pattern_gen_if bus ();

  lbist_pattern_gen dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  // Reference LFSR written with explicit taps 15,14,12,3.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge nRst) begin
    if (!nRst)              m_lfsr <= SEED;
    else if (bus.seed_load) m_lfsr <= (bus.seed_in == 16'h0) ? SEED : bus.seed_in;
    else                    m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};
  end

  logic [IMM_W-1:0]        exp_q[$];
  logic [IMM_W-1:0]        cur_imm [N_RAND];
  logic [N_RAND*IMM_W-1:0] prev_vec;
  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ne(input string tag, input logic [63:0] obs, input logic [63:0] other);
    n_cmp++;
    assert (obs !== other) else begin
      n_err++;
      $error("FAIL %s: observed %h expected a value different from %h", tag, obs, other);
    end
  endtask

  function automatic logic [N_RAND*IMM_W-1:0] cur_vec();
    logic [N_RAND*IMM_W-1:0] v;
    v = '0;
    for (int i = 0; i < N_RAND; i++) v[i*IMM_W +: IMM_W] = cur_imm[i];
    return v;
  endfunction

  // Entered just after the edge that moved the DUT into CAPTURE.
  task automatic capture_round(input string tag);
    logic [IMM_W-1:0] e;
    for (int i = 0; i < N_RAND; i++) begin
      chk($sformatf("%s_valid_low_%0d", tag, i), 64'(bus.rand_valid), 64'(1'b0));
      exp_q.push_back(m_lfsr[IMM_W-1:0]);
      tick();
    end
    chk($sformatf("%s_valid_high", tag), 64'(bus.rand_valid), 64'(1'b1));
    for (int i = 0; i < N_RAND; i++) begin
      e = exp_q.pop_front();
      cur_imm[i] = e;
      chk($sformatf("%s_slot%0d", tag, i), 64'(bus.rand_values[i*IMM_W +: IMM_W]), 64'(e));
    end
  endtask

  initial begin
    bus.TPG        = 1'b0;
    bus.PC         = 32'h0;
    bus.round_next = 1'b0;
    bus.seed_load  = 1'b0;
    bus.seed_in    = 16'h0;

    #12;
    chk("rst_valid",   64'(bus.rand_valid),   64'(1'b0));
    chk("rst_done",    64'(bus.done),         64'(1'b0));
    chk("rst_pattern", 64'(bus.test_pattern), 64'(32'h0));
    chk("rst_round",   64'(bus.round_cnt),    64'(4'd0));
    chk("rst_rand",    64'(bus.rand_values),  64'(48'h0));
    chk("rst_lfsr",    64'(dut.lfsr_q),       64'(SEED));
    nRst = 1'b1;
    tick();

    bus.TPG = 1'b1;
    tick();
    capture_round("r0");

    bus.PC = 32'h4;  #1 chk("pc4_addi",   64'(bus.test_pattern), 64'({cur_imm[1], 20'h00113}));
    bus.PC = 32'h0;  #1 chk("pc0_addi",   64'(bus.test_pattern), 64'({cur_imm[0], 20'h00093}));
    bus.PC = 32'h10; #1 chk("rom_add",    64'(bus.test_pattern), 64'(32'h002082B3));
    bus.PC = 32'h24; #1 chk("rom_sw",     64'(bus.test_pattern), 64'(32'h00102023));
    bus.PC = 32'h44; #1 chk("rom_unused", 64'(bus.test_pattern), 64'(NOP));
    bus.PC = 32'h80; #1 chk("pc_oor",     64'(bus.test_pattern), 64'(NOP));
    bus.PC = 32'h2;  #1 chk("pc_misal",   64'(bus.test_pattern), 64'(NOP));

    bus.seed_load = 1'b1;
    bus.seed_in   = 16'h0;
    tick();
    chk("seed_zero", 64'(dut.lfsr_q), 64'(16'hACE1));
    bus.seed_load = 1'b0;
    tick();
    chk("seed_step", 64'(dut.lfsr_q), 64'(16'h59C3));
    bus.seed_load = 1'b1;
    bus.seed_in   = 16'h1234;
    tick();
    chk("seed_val", 64'(dut.lfsr_q), 64'(16'h1234));
    bus.seed_load = 1'b0;
    tick();

    for (int r = 1; r <= ROUNDS; r++) begin
      prev_vec = cur_vec();
      bus.round_next = 1'b1;
      tick();
      bus.round_next = 1'b0;
      chk($sformatf("round_cnt_%0d", r), 64'(bus.round_cnt), 64'(r));
      if (r < ROUNDS) begin
        bus.PC = 32'h0;
        #1 chk($sformatf("nop_capture_%0d", r), 64'(bus.test_pattern), 64'(NOP));
        capture_round($sformatf("r%0d", r));
        chk_ne($sformatf("fresh_imm_%0d", r), 64'(cur_vec()), 64'(prev_vec));
      end else begin
        chk("done_set",   64'(bus.done),       64'(1'b1));
        chk("done_valid", 64'(bus.rand_valid), 64'(1'b0));
      end
    end

    bus.round_next = 1'b1;
    tick();
    tick();
    bus.round_next = 1'b0;
    chk("round_sat",  64'(bus.round_cnt), 64'(ROUNDS));
    chk("done_hold",  64'(bus.done),      64'(1'b1));

    bus.PC  = 32'h24;
    bus.TPG = 1'b0;
    #1 chk("tpg0_pat_rom", 64'(bus.test_pattern), 64'(32'h0));
    bus.PC = 32'h4;
    #1 chk("tpg0_pat_imm", 64'(bus.test_pattern), 64'(32'h0));
    tick();
    chk("tpg0_round", 64'(bus.round_cnt),   64'(4'd0));
    chk("tpg0_done",  64'(bus.done),        64'(1'b0));
    chk("tpg0_rand",  64'(bus.rand_values), 64'(48'h0));

    bus.TPG = 1'b1;
    tick();
    tick();
    tick();
    chk_ne("mid_cap_partial", 64'(bus.rand_values), 64'(48'h0));
    bus.TPG = 1'b0;
    tick();
    chk("abort_rand",  64'(bus.rand_values), 64'(48'h0));
    chk("abort_valid", 64'(bus.rand_valid),  64'(1'b0));
    bus.TPG = 1'b1;
    tick();
    capture_round("restart");

    bus.round_next = 1'b1;
    bus.TPG        = 1'b0;
    tick();
    bus.round_next = 1'b0;
    chk("tpg_wins_round", 64'(bus.round_cnt),  64'(4'd0));
    chk("tpg_wins_valid", 64'(bus.rand_valid), 64'(1'b0));

    bus.TPG = 1'b1;
    tick();
    capture_round("pre_rst0");
    bus.round_next = 1'b1;
    tick();
    bus.round_next = 1'b0;
    capture_round("pre_rst1");
    chk("pre_rst_round", 64'(bus.round_cnt), 64'(4'd1));
    #2 nRst = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.rand_valid),  64'(1'b0));
    chk("arst_round", 64'(bus.round_cnt),   64'(4'd0));
    chk("arst_rand",  64'(bus.rand_values), 64'(48'h0));
    chk("arst_done",  64'(bus.done),        64'(1'b0));
    chk("arst_lfsr",  64'(dut.lfsr_q),      64'(SEED));
    bus.TPG = 1'b0;
    #1 chk("arst_pat", 64'(bus.test_pattern), 64'(32'h0));
    nRst = 1'b1;
    #1 chk("rel_lfsr", 64'(dut.lfsr_q), 64'(SEED));
    tick();
    chk("rel_step", 64'(dut.lfsr_q), 64'(16'h59C3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
